serial_pattern_transmitter: RTL

//   Serial bit-stream source: loads a WIDTH-bit pattern on a start request and shifts it out
//   MSB-first on a single-bit line, repeating it a programmable number of frames with an

---
 rtl/serial_pattern_transmitter.sv | 112 +++++++++++
 1 files changed

// File: rtl/serial_pattern_transmitter.sv
// Serial pattern source: shifts a latched WIDTH-bit pattern out MSB-first,
// repeated for a programmable number of frames with an optional idle gap.
module serial_pattern_transmitter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [7:0]       frames,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned GW = (GAP < 2) ? 1 : $clog2(GAP);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [BW-1:0]    bit_cnt, bit_cnt_next;
  logic [7:0]       frame_cnt, frame_cnt_next;
  logic [GW-1:0]    gap_cnt, gap_cnt_next;
  logic             out_next, out_valid_next, busy_next, done_next;

  // State, counters and registered outputs; reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      gap_cnt   <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      bit_cnt   <= bit_cnt_next;
      frame_cnt <= frame_cnt_next;
      gap_cnt   <= gap_cnt_next;
      out       <= out_next;
      out_valid <= out_valid_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  // Next-state logic; the shift register rotates so that after a full frame it
  // holds the original pattern again, which doubles as the reload for the next frame.
  always_comb begin
    state_next     = state;
    shreg_next     = shreg;
    bit_cnt_next   = bit_cnt;
    frame_cnt_next = frame_cnt;
    gap_cnt_next   = gap_cnt;
    done_next      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next     = ST_SHIFT;
          shreg_next     = pattern;
          bit_cnt_next   = LAST_BIT;
          frame_cnt_next = (frames == 8'd0) ? 8'd1 : frames;
        end
      end
      ST_SHIFT: begin
        shreg_next = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
        if (bit_cnt != '0) begin
          bit_cnt_next = bit_cnt - BW'(1);
        end else if (frame_cnt > 8'd1) begin
          frame_cnt_next = frame_cnt - 8'd1;
          bit_cnt_next   = LAST_BIT;
          if (GAP > 0) begin
            state_next   = ST_GAP;
            gap_cnt_next = GAP_LOAD;
          end
        end else begin
          state_next     = ST_IDLE;
          frame_cnt_next = 8'd0;
          done_next      = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_next = ST_SHIFT;
        end else begin
          gap_cnt_next = gap_cnt - GW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase

    busy_next      = (state_next != ST_IDLE);
    out_valid_next = (state_next == ST_SHIFT);
    out_next       = (state_next == ST_SHIFT) & shreg_next[WIDTH-1];
  end

endmodule
